// File: rtl/design_select_pkg.sv
// Shared types and defaults for the pad-sharing design selector.
package design_select_pkg;

  localparam int unsigned N_DESIGNS_DEFAULT   = 4;
  localparam int unsigned RES_W_DEFAULT       = 5;
  localparam int unsigned HOLD_CYCLES_DEFAULT = 8;

  // Result driven onto the pads once a full scan has completed.
  localparam logic [63:0] DONE_PATTERN = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_HOLD,
    ST_SCAN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: combinational winner search plus last_grant register.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic                 advance,
  output logic                 found,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] winner_idx
);

  localparam int unsigned IDX_W = $clog2(N);

  logic [IDX_W-1:0] last_grant;

  // Search upward from last_grant+1 with wrap-around; first asserted request wins.
  always_comb begin
    logic [IDX_W-1:0] cand;
    found      = 1'b0;
    grant      = '0;
    winner_idx = '0;
    cand       = '0;
    for (int unsigned off = 1; off <= N; off++) begin
      cand = IDX_W'((32'(last_grant) + off) % N);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        winner_idx  = cand;
      end
    end
  end

  // Remember the winner so the next search starts just past it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= IDX_W'(N - 1);
    end else if (advance && found) begin
      last_grant <= winner_idx;
    end
  end

endmodule

// File: rtl/design_select_ctrl.sv
// Selects which user design drives the shared result pads: round-robin
// arbitration in normal mode, a fixed sequential sweep in scan mode.
module design_select_ctrl
  import design_select_pkg::*;
#(
  parameter int unsigned N_DESIGNS   = N_DESIGNS_DEFAULT,
  parameter int unsigned RES_W       = RES_W_DEFAULT,
  parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEFAULT
) (
  input  logic                         wb_clk_i,
  input  logic                         wb_rst_i,
  input  logic                         i_enable,
  input  logic                         i_test,
  input  logic [N_DESIGNS-1:0]         req_i,
  input  logic [N_DESIGNS*RES_W-1:0]   res_i,
  output logic [N_DESIGNS-1:0]         gnt_o,
  output logic [RES_W-1:0]             o_result,
  output logic                         o_busy
);

  localparam int unsigned IDX_W = $clog2(N_DESIGNS);
  localparam int unsigned CNT_W = $clog2(HOLD_CYCLES + 1);

  localparam logic [CNT_W-1:0]     CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(N_DESIGNS - 1);
  localparam logic [N_DESIGNS-1:0] ONE_HOT0 = N_DESIGNS'(1);
  localparam logic [RES_W-1:0]     DONE_RES = DONE_PATTERN[RES_W-1:0];

  state_e           state;
  logic             en_meta, en_s, en_prev;
  logic             test_meta, test_s;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] scan_idx;
  logic [IDX_W-1:0] cur_idx;

  logic [RES_W-1:0] slices [N_DESIGNS];
  logic [RES_W-1:0] cur_slice;

  logic                 arb_found;
  logic                 arb_advance;
  logic [N_DESIGNS-1:0] arb_grant;
  logic [IDX_W-1:0]     arb_idx;

  for (genvar k = 0; k < N_DESIGNS; k++) begin : g_slice
    assign slices[k] = res_i[k*RES_W +: RES_W];
  end

  // Result slice of the design currently holding the grant.
  always_comb begin
    cur_slice = slices[cur_idx];
  end

  // Commit a new last_grant only on the edge that actually issues the grant.
  always_comb begin
    arb_advance = (state == ST_ARB) && en_s;
  end

  rr_arbiter #(
    .N(N_DESIGNS)
  ) u_arb (
    .clk        (wb_clk_i),
    .rst        (wb_rst_i),
    .req        (req_i),
    .advance    (arb_advance),
    .found      (arb_found),
    .grant      (arb_grant),
    .winner_idx (arb_idx)
  );

  // Two-flop synchronizers for the pad-level enable and scan select.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      en_meta   <= 1'b0;
      en_s      <= 1'b0;
      test_meta <= 1'b0;
      test_s    <= 1'b0;
    end else begin
      en_meta   <= i_enable;
      en_s      <= en_meta;
      test_meta <= i_test;
      test_s    <= test_meta;
    end
  end

  // Control FSM with registered grant, result and busy outputs.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state    <= ST_IDLE;
      en_prev  <= 1'b0;
      gnt_o    <= '0;
      o_result <= '0;
      o_busy   <= 1'b0;
      cnt      <= '0;
      scan_idx <= '0;
      cur_idx  <= '0;
    end else begin
      en_prev <= en_s;
      if ((state != ST_IDLE) && !en_s) begin
        state    <= ST_IDLE;
        gnt_o    <= '0;
        o_result <= '0;
        o_busy   <= 1'b0;
        cnt      <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            gnt_o    <= '0;
            o_result <= '0;
            o_busy   <= 1'b0;
            if (en_s && !en_prev) begin
              if (test_s) begin
                state    <= ST_SCAN;
                scan_idx <= '0;
                cur_idx  <= '0;
                gnt_o    <= ONE_HOT0;
                cnt      <= CNT_LOAD;
                o_busy   <= 1'b1;
              end else begin
                state <= ST_ARB;
              end
            end
          end
          ST_ARB: begin
            gnt_o    <= '0;
            o_result <= '0;
            o_busy   <= 1'b0;
            if (arb_found) begin
              state   <= ST_HOLD;
              gnt_o   <= arb_grant;
              cur_idx <= arb_idx;
              cnt     <= CNT_LOAD;
              o_busy  <= 1'b1;
            end
          end
          ST_HOLD: begin
            if (cnt != '0) begin
              cnt      <= cnt - 1'b1;
              o_result <= cur_slice;
            end else begin
              state    <= ST_ARB;
              gnt_o    <= '0;
              o_result <= '0;
              o_busy   <= 1'b0;
            end
          end
          // Slot boundaries keep reporting the outgoing design's slice for one
          // more cycle; only the final slot hands over to the done pattern.
          ST_SCAN: begin
            if (cnt != '0) begin
              cnt      <= cnt - 1'b1;
              o_result <= cur_slice;
            end else if (scan_idx == LAST_IDX) begin
              state    <= ST_DONE;
              gnt_o    <= '0;
              o_result <= DONE_RES;
              o_busy   <= 1'b0;
            end else begin
              scan_idx <= scan_idx + 1'b1;
              cur_idx  <= scan_idx + 1'b1;
              gnt_o    <= ONE_HOT0 << (scan_idx + 1'b1);
              cnt      <= CNT_LOAD;
              o_result <= cur_slice;
            end
          end
          ST_DONE: begin
            gnt_o    <= '0;
            o_result <= DONE_RES;
            o_busy   <= 1'b0;
          end
          default: begin
            state    <= ST_IDLE;
            gnt_o    <= '0;
            o_result <= '0;
            o_busy   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_design_select_ctrl.sv
// Self-checking bench for design_select_ctrl against a grant-schedule model.
module tb_design_select_ctrl;

  localparam int N  = 4;
  localparam int W  = 5;
  localparam int H  = 8;
  localparam int RW = N * W;

  logic          clk = 1'b0;
  logic          wb_rst_i = 1'b1;
  logic          i_enable = 1'b0;
  logic          i_test = 1'b0;
  logic [N-1:0]  req_i = '0;
  logic [RW-1:0] res_i = '0;
  logic [N-1:0]  gnt_o;
  logic [W-1:0]  o_result;
  logic          o_busy;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  design_select_ctrl #(
    .N_DESIGNS   (N),
    .RES_W       (W),
    .HOLD_CYCLES (H)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (wb_rst_i),
    .i_enable (i_enable),
    .i_test   (i_test),
    .req_i    (req_i),
    .res_i    (res_i),
    .gnt_o    (gnt_o),
    .o_result (o_result),
    .o_busy   (o_busy)
  );

  // Reference model: a queue of upcoming per-cycle grant indices.
  typedef enum {M_OFF, M_ARB, M_GRANT, M_DONE} mmode_e;
  mmode_e       m_mode;
  int           plan[$];
  bit           m_scan;
  int           m_ptr;
  int           m_cur;
  bit           m_en1, m_en2, m_t1, m_t2, m_en_prev;
  logic [N-1:0] exp_gnt;
  logic [W-1:0] exp_res;
  logic         exp_busy;

  function automatic void model_reset();
    m_mode = M_OFF;
    plan.delete();
    m_scan = 1'b0;
    m_ptr = 0;
    m_cur = -1;
    m_en1 = 1'b0; m_en2 = 1'b0; m_t1 = 1'b0; m_t2 = 1'b0; m_en_prev = 1'b0;
    exp_gnt = '0; exp_res = '0; exp_busy = 1'b0;
  endfunction

  function automatic void model_step();
    bit en_s, te_s;
    logic [W-1:0] cur_slice;
    int win;
    en_s = m_en2;
    te_s = m_t2;
    cur_slice = '0;
    if (m_cur >= 0) cur_slice = W'(res_i >> (m_cur * W));
    if (m_mode != M_OFF && !en_s) begin
      m_mode = M_OFF;
      plan.delete();
      m_cur = -1;
      exp_res = '0;
    end else begin
      case (m_mode)
        M_OFF: begin
          exp_res = '0;
          m_cur = -1;
          if (en_s && !m_en_prev) begin
            if (te_s) begin
              for (int d = 0; d < N; d++)
                for (int r = 0; r < H; r++) plan.push_back(d);
              m_scan = 1'b1;
              m_mode = M_GRANT;
              m_cur = plan.pop_front();
            end else begin
              m_mode = M_ARB;
            end
          end
        end
        M_ARB: begin
          exp_res = '0;
          m_cur = -1;
          win = -1;
          for (int k = 0; k < N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (win < 0 && 1'(req_i >> c)) win = c;
          end
          if (win >= 0) begin
            for (int r = 0; r < H; r++) plan.push_back(win);
            m_scan = 1'b0;
            m_mode = M_GRANT;
            m_ptr = (win + 1) % N;
            m_cur = plan.pop_front();
          end
        end
        M_GRANT: begin
          if (plan.size() > 0) begin
            exp_res = cur_slice;
            m_cur = plan.pop_front();
          end else if (m_scan) begin
            m_mode = M_DONE;
            m_cur = -1;
            exp_res = '1;
          end else begin
            m_mode = M_ARB;
            m_cur = -1;
            exp_res = '0;
          end
        end
        default: begin
          m_cur = -1;
          exp_res = '1;
        end
      endcase
    end
    exp_gnt = '0;
    if (m_cur >= 0) exp_gnt = N'(1) << m_cur;
    exp_busy = (m_mode == M_GRANT);
    m_en_prev = en_s;
    m_en2 = m_en1; m_en1 = i_enable;
    m_t2 = m_t1;   m_t1 = i_test;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    wb_rst_i = 1'b1;
    i_enable = 1'b0; i_test = 1'b0; req_i = '0; res_i = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    wb_rst_i = 1'b0;
  endtask

  task automatic test_reset();
    wb_rst_i = 1'b1;
    i_enable = 1'b0; i_test = 1'b0; req_i = '0; res_i = '0;
    model_reset();
    #1;
    checks++;
    if (gnt_o !== '0 || o_result !== '0 || o_busy !== 1'b0)
      $display("FAIL reset_state: gnt_o=%b o_result=%h o_busy=%b, expected all zero", gnt_o, o_result, o_busy);
    else passes++;
    i_enable = 1'b1; req_i = '1; res_i = RW'($urandom);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (gnt_o !== '0 || o_result !== '0 || o_busy !== 1'b0)
        $display("FAIL reset_held cyc %0d: gnt_o=%b o_result=%h o_busy=%b, expected all zero", i, gnt_o, o_result, o_busy);
      else passes++;
    end
    @(negedge clk);
    wb_rst_i = 1'b0;
  endtask

  task automatic test_enable_low();
    do_reset();
    i_enable = 1'b0; req_i = '1;
    for (int i = 0; i < 20; i++) begin
      res_i = RW'($urandom);
      tick();
      checks++;
      if (gnt_o !== '0 || o_result !== '0 || o_busy !== 1'b0)
        $display("FAIL enable_low cyc %0d: gnt_o=%b o_result=%h o_busy=%b, expected all zero", i, gnt_o, o_result, o_busy);
      else passes++;
    end
  endtask

  task automatic test_round_robin();
    int seq[$];
    int runlen[$];
    logic [N-1:0] prev;
    int want[5] = '{0, 1, 2, 3, 0};
    do_reset();
    prev = '0;
    i_enable = 1'b1; i_test = 1'b0; req_i = 4'b1111;
    res_i = {5'd4, 5'd3, 5'd2, 5'd1};
    for (int i = 0; i < 50; i++) begin
      tick();
      checks++;
      if (gnt_o !== exp_gnt || o_result !== exp_res || o_busy !== exp_busy)
        $display("FAIL round_robin cyc %0d: gnt_o=%b o_result=%h o_busy=%b, expected %b %h %b",
                 i, gnt_o, o_result, o_busy, exp_gnt, exp_res, exp_busy);
      else passes++;
      if (gnt_o != '0) begin
        if (gnt_o != prev) begin
          seq.push_back($clog2(gnt_o));
          runlen.push_back(1);
        end else begin
          runlen[runlen.size()-1] = runlen[runlen.size()-1] + 1;
        end
      end
      prev = gnt_o;
    end
    for (int j = 0; j < 5; j++) begin
      checks++;
      if (seq.size() <= j)
        $display("FAIL rr_order grant %0d: missing, expected design %0d", j, want[j]);
      else if (seq[j] != want[j])
        $display("FAIL rr_order grant %0d: design %0d, expected design %0d", j, seq[j], want[j]);
      else passes++;
    end
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (runlen.size() <= j || runlen[j] != H)
        $display("FAIL rr_hold_len grant %0d: %0d cycles, expected %0d", j,
                 (runlen.size() > j) ? runlen[j] : -1, H);
      else passes++;
    end
  endtask

  task automatic test_nonpreempt();
    int held;
    do_reset();
    held = 0;
    i_enable = 1'b1; i_test = 1'b0; req_i = 4'b0100;
    for (int i = 0; i < 30; i++) begin
      res_i = RW'($urandom);
      tick();
      checks++;
      if (gnt_o !== exp_gnt || o_result !== exp_res || o_busy !== exp_busy)
        $display("FAIL nonpreempt cyc %0d: gnt_o=%b o_result=%h o_busy=%b, expected %b %h %b",
                 i, gnt_o, o_result, o_busy, exp_gnt, exp_res, exp_busy);
      else passes++;
      if (gnt_o == 4'b0100) held++;
      if (held == 2) req_i = '0;
    end
    checks++;
    if (held != H) $display("FAIL nonpreempt_len: held %0d cycles, expected %0d", held, H);
    else passes++;
    checks++;
    if (gnt_o !== '0 || o_busy !== 1'b0 || o_result !== '0)
      $display("FAIL nonpreempt_arb: gnt_o=%b o_busy=%b o_result=%h, expected 0 0 0", gnt_o, o_busy, o_result);
    else passes++;
  endtask

  task automatic test_scan();
    int granted;
    logic [N-1:0] last_g;
    do_reset();
    granted = 0;
    last_g = '0;
    i_enable = 1'b1; i_test = 1'b1;
    for (int i = 0; i < 40; i++) begin
      req_i = N'($urandom); res_i = RW'($urandom);
      tick();
      checks++;
      if (gnt_o !== exp_gnt || o_result !== exp_res || o_busy !== exp_busy)
        $display("FAIL scan cyc %0d: gnt_o=%b o_result=%h o_busy=%b, expected %b %h %b",
                 i, gnt_o, o_result, o_busy, exp_gnt, exp_res, exp_busy);
      else passes++;
      if (gnt_o != '0) begin granted++; last_g = gnt_o; end
    end
    checks++;
    if (granted != N * H || last_g !== 4'b1000)
      $display("FAIL scan_slots: %0d grant cycles ending on %b, expected %0d ending on 1000", granted, last_g, N * H);
    else passes++;
    checks++;
    if (o_result !== 5'b11111 || gnt_o !== '0)
      $display("FAIL scan_done: o_result=%b gnt_o=%b, expected 11111 0000", o_result, gnt_o);
    else passes++;
    i_enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (gnt_o !== exp_gnt || o_result !== exp_res || o_busy !== exp_busy)
        $display("FAIL scan_disable cyc %0d: gnt_o=%b o_result=%h o_busy=%b, expected %b %h %b",
                 i, gnt_o, o_result, o_busy, exp_gnt, exp_res, exp_busy);
      else passes++;
    end
    checks++;
    if (o_result !== '0) $display("FAIL scan_disable_res: o_result=%b, expected 00000", o_result);
    else passes++;
  endtask

  task automatic test_reset_mid_hold();
    bit seen;
    do_reset();
    i_enable = 1'b1; i_test = 1'b0; req_i = 4'b1111;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      res_i = RW'($urandom);
      tick();
      checks++;
      if (gnt_o !== exp_gnt || o_result !== exp_res || o_busy !== exp_busy)
        $display("FAIL rst_hold_pre cyc %0d: gnt_o=%b o_result=%h o_busy=%b, expected %b %h %b",
                 i, gnt_o, o_result, o_busy, exp_gnt, exp_res, exp_busy);
      else passes++;
      if (gnt_o != '0) seen = 1'b1;
    end
    checks++;
    if (!seen) $display("FAIL rst_hold_grant: no grant within 12 cycles, expected one");
    else passes++;
    for (int i = 0; i < 3; i++) tick();
    #2;
    wb_rst_i = 1'b1;
    #1;
    checks++;
    if (gnt_o !== '0 || o_result !== '0 || o_busy !== 1'b0)
      $display("FAIL rst_hold_abort: gnt_o=%b o_result=%h o_busy=%b, expected all zero", gnt_o, o_result, o_busy);
    else passes++;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    wb_rst_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      tick();
      checks++;
      if (gnt_o !== exp_gnt || o_result !== exp_res || o_busy !== exp_busy)
        $display("FAIL rst_hold_post cyc %0d: gnt_o=%b o_result=%h o_busy=%b, expected %b %h %b",
                 i, gnt_o, o_result, o_busy, exp_gnt, exp_res, exp_busy);
      else passes++;
      if (gnt_o != '0) seen = 1'b1;
    end
    checks++;
    if (gnt_o !== 4'b0001) $display("FAIL rst_hold_restart: gnt_o=%b, expected 0001", gnt_o);
    else passes++;
  endtask

  task automatic test_scan_abort();
    bit seen;
    do_reset();
    i_enable = 1'b1; i_test = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      req_i = N'($urandom); res_i = RW'($urandom);
      tick();
      checks++;
      if (gnt_o !== exp_gnt || o_result !== exp_res || o_busy !== exp_busy)
        $display("FAIL scan_abort_pre cyc %0d: gnt_o=%b o_result=%h o_busy=%b, expected %b %h %b",
                 i, gnt_o, o_result, o_busy, exp_gnt, exp_res, exp_busy);
      else passes++;
      if (gnt_o == 4'b0100) seen = 1'b1;
    end
    checks++;
    if (!seen) $display("FAIL scan_abort_slot2: slot 2 not reached within 30 cycles, expected it");
    else passes++;
    tick(); tick();
    i_enable = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (gnt_o !== '0 || o_busy !== 1'b0 || o_result !== '0)
      $display("FAIL scan_abort_idle: gnt_o=%b o_busy=%b o_result=%h, expected 0 0 0", gnt_o, o_busy, o_result);
    else passes++;
    i_enable = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      res_i = RW'($urandom);
      tick();
      checks++;
      if (gnt_o !== exp_gnt || o_result !== exp_res || o_busy !== exp_busy)
        $display("FAIL scan_abort_post cyc %0d: gnt_o=%b o_result=%h o_busy=%b, expected %b %h %b",
                 i, gnt_o, o_result, o_busy, exp_gnt, exp_res, exp_busy);
      else passes++;
      if (gnt_o != '0) seen = 1'b1;
    end
    checks++;
    if (gnt_o !== 4'b0001) $display("FAIL scan_abort_restart: gnt_o=%b, expected 0001", gnt_o);
    else passes++;
  endtask

  task automatic test_random();
    do_reset();
    i_enable = 1'b1;
    for (int i = 0; i < 600; i++) begin
      req_i = N'($urandom);
      res_i = RW'($urandom);
      if ($urandom_range(0, 99) < 3) i_enable = ~i_enable;
      if ($urandom_range(0, 99) < 5) i_test = ~i_test;
      tick();
      checks++;
      if (gnt_o !== exp_gnt || o_result !== exp_res || o_busy !== exp_busy)
        $display("FAIL random cyc %0d: gnt_o=%b o_result=%h o_busy=%b, expected %b %h %b",
                 i, gnt_o, o_result, o_busy, exp_gnt, exp_res, exp_busy);
      else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_enable_low();
    test_round_robin();
    test_nonpreempt();
    test_scan();
    test_reset_mid_hold();
    test_scan_abort();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
